// File: rtl/pong_pkg.sv
// Shared pong constants and the paddle controller state encoding.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PADDLE_H = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_SLOW = 2'd1,
    MOVE_FAST = 2'd2
  } paddle_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } paddle_dir_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller control/status bundle: frame tick, buttons and freeze in,
// position and flags out.
interface paddle_ctrl_if #(
  parameter int W = 10
) ();

  logic         tick;
  logic         btn_up;
  logic         btn_down;
  logic         freeze;
  logic [W-1:0] paddle_y;
  logic         moving;
  logic         at_top;
  logic         at_bottom;

  modport master (
    output tick, btn_up, btn_down, freeze,
    input  paddle_y, moving, at_top, at_bottom
  );

  modport slave (
    input  tick, btn_up, btn_down, freeze,
    output paddle_y, moving, at_top, at_bottom
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a slow asynchronous level, cleared by rst_n.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle vertical position controller: per-frame motion with hold acceleration
// and clamping to the playfield.
//   state     | meaning
//   IDLE      | no request, paddle stationary
//   MOVE_SLOW | moving SPEED_LO per tick, counting held ticks
//   MOVE_FAST | moving SPEED_HI per tick after ACCEL_TICKS slow moves
module paddle_ctrl #(
  parameter int W           = 10,
  parameter int Y_TOP       = 0,
  parameter int Y_BOTTOM    = pong_pkg::V_ACTIVE - 1,
  parameter int PADDLE_H    = pong_pkg::PADDLE_H,
  parameter int Y_RESET     = (Y_BOTTOM + 1 - PADDLE_H) / 2,
  parameter int SPEED_LO    = 2,
  parameter int SPEED_HI    = 6,
  parameter int ACCEL_TICKS = 8
) (
  input logic           clk,
  input logic           rst_n,
  paddle_ctrl_if.slave  bus
);

  import pong_pkg::*;

  localparam int         Y_MAX = Y_BOTTOM + 1 - PADDLE_H;
  localparam int         CW    = $clog2(ACCEL_TICKS + 1);
  localparam logic [W:0] TOP_X = (W+1)'(Y_TOP);
  localparam logic [W:0] MAX_X = (W+1)'(Y_MAX);
  localparam logic [W:0] LO_X  = (W+1)'(SPEED_LO);
  localparam logic [W:0] HI_X  = (W+1)'(SPEED_HI);

  logic up_s, down_s;

  btn_sync u_sync_up (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_up),
    .q     (up_s)
  );

  btn_sync u_sync_down (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_down),
    .q     (down_s)
  );

  logic        req_up, req_down, req_any;
  paddle_dir_e req_dir;

  assign req_up   = up_s & ~down_s & ~bus.freeze;
  assign req_down = down_s & ~up_s & ~bus.freeze;
  assign req_any  = req_up | req_down;
  assign req_dir  = req_down ? DIR_DOWN : DIR_UP;

  paddle_state_e   state, state_nxt;
  paddle_dir_e     dir, dir_nxt;
  logic [CW-1:0]   hold_cnt, hold_nxt;
  logic [W-1:0]    y, y_nxt;
  logic            move_en;
  logic [W:0]      spd, y_ext;
  logic            moving_r, at_top_r, at_bottom_r;

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    hold_nxt  = hold_cnt;
    move_en   = 1'b0;
    spd       = LO_X;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_nxt = MOVE_SLOW;
          dir_nxt   = req_dir;
          hold_nxt  = CW'(1);
          move_en   = 1'b1;
        end
      end
      MOVE_SLOW, MOVE_FAST: begin
        if (!req_any) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (req_dir != dir) begin
          // A reversal always restarts the slow phase.
          state_nxt = MOVE_SLOW;
          dir_nxt   = req_dir;
          hold_nxt  = CW'(1);
          move_en   = 1'b1;
        end else if (state == MOVE_FAST) begin
          move_en = 1'b1;
          spd     = HI_X;
        end else if (hold_cnt < CW'(ACCEL_TICKS)) begin
          move_en  = 1'b1;
          hold_nxt = hold_cnt + CW'(1);
        end else begin
          state_nxt = MOVE_FAST;
          move_en   = 1'b1;
          spd       = HI_X;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // One extra bit keeps the clamp compares free of wrap-around.
  always_comb begin
    y_ext = {1'b0, y};
    y_nxt = y;
    if (move_en) begin
      if (dir_nxt == DIR_UP) begin
        if (y_ext < TOP_X + spd) y_nxt = W'(TOP_X);
        else                     y_nxt = W'(y_ext - spd);
      end else begin
        if (y_ext + spd > MAX_X) y_nxt = W'(MAX_X);
        else                     y_nxt = W'(y_ext + spd);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dir         <= DIR_UP;
      hold_cnt    <= '0;
      y           <= W'(Y_RESET);
      moving_r    <= 1'b0;
      at_top_r    <= 1'b0;
      at_bottom_r <= 1'b0;
    end else if (bus.tick) begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      hold_cnt    <= hold_nxt;
      y           <= y_nxt;
      moving_r    <= (state_nxt != IDLE);
      at_top_r    <= (y_nxt == W'(TOP_X));
      at_bottom_r <= (y_nxt == W'(MAX_X));
    end
  end

  assign bus.paddle_y  = y;
  assign bus.moving    = moving_r;
  assign bus.at_top    = at_top_r;
  assign bus.at_bottom = at_bottom_r;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: directed button sequences with hand-computed positions.
module tb_paddle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paddle_ctrl_if #(.W(10)) bus ();

  paddle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0] y;
    logic       moving;
    logic       at_top;
    logic       at_bottom;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_req  = 1'b0;
  event sample_ev;

  task automatic compare_one();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: output sampled with nothing expected (y=%0d)", bus.paddle_y);
      return;
    end
    e = sb.pop_front();
    if (bus.paddle_y !== e.y || bus.moving !== e.moving ||
        bus.at_top !== e.at_top || bus.at_bottom !== e.at_bottom) begin
      n_fail++;
      $display("FAIL %s: got y=%0d moving=%b at_top=%b at_bottom=%b, expected y=%0d moving=%b at_top=%b at_bottom=%b",
               e.name, bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom,
               e.y, e.moving, e.at_top, e.at_bottom);
    end
  endtask

  // Monitor: a checked tick presents its result one edge later.
  always @(posedge clk) begin
    if (bus.tick === 1'b1 && chk_req) begin
      #1;
      compare_one();
    end
  end

  always @(sample_ev) compare_one();

  function automatic void push_exp(input int y, input bit m, input bit t, input bit b, input string name);
    exp_t e;
    e.y = 10'(y); e.moving = m; e.at_top = t; e.at_bottom = b; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic set_btn(input bit up, input bit down);
    @(negedge clk);
    bus.btn_up   = up;
    bus.btn_down = down;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick(input bit chk, input int y, input bit m, input bit t, input bit b, input string name);
    @(negedge clk);
    bus.tick = 1'b1;
    chk_req  = chk;
    if (chk) push_exp(y, m, t, b, name);
    @(negedge clk);
    bus.tick = 1'b0;
    chk_req  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0, 0, 1'b0, 1'b0, 1'b0, "");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.freeze   = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(208, 0, 0, 0, "reset_held");
    ->sample_ev;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_exp(208, 0, 0, 0, "reset_released");
    ->sample_ev;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick     = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.freeze   = 1'b0;

    do_reset();

    // Short up hold, then release.
    set_btn(1, 0);
    do_tick(1, 206, 1, 0, 0, "up_tick1");
    do_tick(1, 204, 1, 0, 0, "up_tick2");
    do_tick(1, 202, 1, 0, 0, "up_tick3");
    set_btn(0, 0);
    do_tick(1, 202, 0, 0, 0, "release_idle");

    // Down hold through acceleration: 8 slow ticks then fast.
    do_reset();
    set_btn(0, 1);
    ticks(7);
    do_tick(1, 224, 1, 0, 0, "down_slow_last");
    do_tick(1, 230, 1, 0, 0, "down_first_fast");
    do_tick(1, 236, 1, 0, 0, "down_10ticks");

    // Run to the top, then come back to y=4 and approach the top slowly.
    set_btn(0, 0);
    do_tick(1, 236, 0, 0, 0, "idle_after_down");
    set_btn(1, 0);
    ticks(44);
    do_tick(1, 0, 1, 1, 0, "up_clamp_top");
    set_btn(0, 0);
    do_tick(1, 0, 0, 1, 0, "idle_at_top");
    set_btn(0, 1);
    do_tick(1, 2, 1, 0, 0, "leave_top");
    do_tick(1, 4, 1, 0, 0, "reach_4");
    set_btn(0, 0);
    do_tick(1, 4, 0, 0, 0, "idle_at_4");
    set_btn(1, 0);
    do_tick(1, 2, 1, 0, 0, "from4_to2");
    do_tick(1, 0, 1, 1, 0, "from2_to0");
    do_tick(1, 0, 1, 1, 0, "hold_at_top");

    // Reverse at the top and run fast into the bottom.
    set_btn(0, 1);
    do_tick(1, 2, 1, 0, 0, "reverse_at_top");
    ticks(72);
    do_tick(1, 412, 1, 0, 0, "near_bottom");
    do_tick(1, 416, 1, 0, 1, "clamp_bottom");
    do_tick(1, 416, 1, 0, 1, "hold_at_bottom");

    // Both buttons are no request; then reversal restarts the slow phase.
    do_reset();
    set_btn(1, 1);
    for (int i = 0; i < 5; i++) do_tick(1, 208, 0, 0, 0, "both_pressed");
    set_btn(1, 0);
    ticks(9);
    do_tick(1, 180, 1, 0, 0, "up_10ticks");
    set_btn(0, 1);
    do_tick(1, 182, 1, 0, 0, "reverse_slow_restart");
    ticks(7);
    do_tick(1, 202, 1, 0, 0, "reverse_reaches_fast");

    // Freeze during fast motion, resume, then async reset mid-move.
    bus.freeze = 1'b1;
    do_tick(1, 202, 0, 0, 0, "freeze_fast");
    bus.freeze = 1'b0;
    do_tick(1, 204, 1, 0, 0, "resume_slow");
    do_tick(1, 206, 1, 0, 0, "resume_slow2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(208, 0, 0, 0, "async_reset");
    ->sample_ev;
    do_tick(1, 208, 0, 0, 0, "tick_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
